// File: rtl/blend_weight_seq.sv
// -----------------------------------------------------------------------------
// blend_weight_seq
//
// Computes the static and fast blend weights (w_s, w_f) from an absolute pixel
// difference and a pair of blend thresholds. Both weights share one restoring
// divider that runs 8 iterations per weight, fast weight first, then static.
//
//   w_f = floor((df*256-1)/D), df = diff - th0
//   w_s = floor((ds*256-1)/D), ds = th1 - diff
//   D   = th1 - th0
//
// A zero operand gives a zero weight. Saturated, inverted and zero-span cases
// skip the divider and finish two cycles after the accept.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   in_valid   : request valid (diff, blend_th0, blend_th1)
//   in_ready   : block idle and able to accept a request
//   diff       : absolute pixel difference, pixelBitWidth+1 bits
//   blend_th0  : lower blend threshold
//   blend_th1  : upper blend threshold
//   out_valid  : w_s / w_f hold a new result, held until out_ready
//   out_ready  : consumer takes the result
//   w_s        : static weight (registered)
//   w_f        : fast weight (registered)
//   busy       : high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module blend_weight_seq #(
   parameter int pixelBitWidth     = 12,
   parameter int thresholdBitWidth = 9
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [pixelBitWidth:0]       diff,
   input  logic [thresholdBitWidth-1:0] blend_th0,
   input  logic [thresholdBitWidth-1:0] blend_th1,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [7:0]                   w_s,
   output logic [7:0]                   w_f,
   output logic                         busy
);

   localparam int DW = pixelBitWidth + 1;
   localparam int TW = thresholdBitWidth;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      DIV_F,
      DIV_S,
      DONE
   } state_t;

   // Divider start-up values for one operand.
   typedef struct packed {
      logic [TW-1:0] rem;   // initial partial remainder N[TW+7:8]
      logic [7:0]    lo;    // dividend bits still to be shifted in
      logic          zero;  // operand was zero: quotient forced to 0
   } div_init_t;

   // Dividend N = d*256-1. Its upper part equals d-1, which is below D
   // because d <= D, so the quotient always fits in 8 bits.
   function automatic div_init_t div_load(input logic [TW-1:0] d);
      div_init_t     r;
      logic [TW+7:0] n;
      n = {d, 8'h00} - (TW+8)'(1);
      if (d == '0) begin
         r.rem  = '0;
         r.lo   = '0;
         r.zero = 1'b1;
      end else begin
         r.rem  = n[TW+7:8];
         r.lo   = n[7:0];
         r.zero = 1'b0;
      end
      return r;
   endfunction

   state_t        state;
   logic [DW-1:0] diff_q;
   logic [TW-1:0] th0_q;
   logic [TW-1:0] th1_q;
   logic [TW-1:0] div_d;    // divisor D = th1 - th0
   logic [TW-1:0] ds_q;     // static-weight operand, waits for DIV_S
   logic [TW-1:0] rem;
   logic [7:0]    n_lo;
   logic [6:0]    quo;      // quotient bits gathered so far
   logic          zero_op;
   logic [2:0]    cnt;

   // ---------------------------------------------------------------------
   // Threshold classification of the registered request
   // ---------------------------------------------------------------------
   logic          lt;
   logic          gt;
   logic [TW-1:0] span;
   logic [TW-1:0] df;
   logic [TW-1:0] ds;

   // NOTE: every signal written in an always_comb block gets a value on every
   // path (defaults first); a missed path would infer a latch.
   always_comb begin
      lt   = diff_q < {{(DW-TW){1'b0}}, th0_q};
      gt   = diff_q > {{(DW-TW){1'b0}}, th1_q};
      span = th1_q - th0_q;
      // Only used when th0 <= diff <= th1, so the low TW bits are exact.
      df   = diff_q[TW-1:0] - th0_q;
      ds   = th1_q - diff_q[TW-1:0];
   end

   // ---------------------------------------------------------------------
   // One restoring-division iteration
   // ---------------------------------------------------------------------
   logic [TW:0]   shifted;
   logic          ge;
   logic [TW-1:0] rem_next;
   logic [7:0]    q_next;

   always_comb begin
      shifted  = {rem, n_lo[7]};
      ge       = shifted >= {1'b0, div_d};
      rem_next = shifted[TW-1:0];
      // rem < D, so shifted < 2D and the difference fits in TW bits.
      if (ge) rem_next = shifted[TW-1:0] - div_d;
      q_next   = {quo, ge};
   end

   // ---------------------------------------------------------------------
   // Control FSM and registered outputs
   // ---------------------------------------------------------------------
   div_init_t init_f;
   div_init_t init_s;

   always_comb begin
      init_f = div_load(df);
      init_s = div_load(ds_q);
   end

   // NOTE: all state below is sequential and uses non-blocking assignments so
   // every register samples values from before the clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         diff_q    <= '0;
         th0_q     <= '0;
         th1_q     <= '0;
         div_d     <= '0;
         ds_q      <= '0;
         rem       <= '0;
         n_lo      <= '0;
         quo       <= '0;
         zero_op   <= 1'b0;
         cnt       <= '0;
         w_s       <= '0;
         w_f       <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  diff_q   <= diff;
                  th0_q    <= blend_th0;
                  th1_q    <= blend_th1;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= CHECK;
               end
            end

            CHECK: begin
               if (lt && gt) begin
                  // Inverted thresholds: no meaningful blend.
                  w_s       <= 8'h00;
                  w_f       <= 8'h00;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (lt || (!gt && span == '0)) begin
                  w_s       <= 8'hFF;
                  w_f       <= 8'h00;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (gt) begin
                  w_s       <= 8'h00;
                  w_f       <= 8'hFF;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  div_d   <= span;
                  ds_q    <= ds;
                  rem     <= init_f.rem;
                  n_lo    <= init_f.lo;
                  zero_op <= init_f.zero;
                  cnt     <= '0;
                  state   <= DIV_F;
               end
            end

            DIV_F: begin
               rem  <= rem_next;
               n_lo <= {n_lo[6:0], 1'b0};
               quo  <= q_next[6:0];
               cnt  <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  w_f     <= zero_op ? 8'h00 : q_next;
                  rem     <= init_s.rem;
                  n_lo    <= init_s.lo;
                  zero_op <= init_s.zero;
                  state   <= DIV_S;
               end
            end

            DIV_S: begin
               rem  <= rem_next;
               n_lo <= {n_lo[6:0], 1'b0};
               quo  <= q_next[6:0];
               cnt  <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  w_s       <= zero_op ? 8'h00 : q_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_blend_weight_seq.sv
// -----------------------------------------------------------------------------
// tb_blend_weight_seq
//
// Directed requests with hand-computed weights. The stimulus process pushes the
// expected weights, the expected first out_valid cycle and a backpressure
// length into a queue; the monitor process pops an entry whenever the DUT
// raises out_valid and checks weights, latency and hold behaviour.
// -----------------------------------------------------------------------------
module tb_blend_weight_seq;

   localparam int PW = 12;
   localparam int TW = 9;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid;
   logic          in_ready;
   logic [PW:0]   diff;
   logic [TW-1:0] blend_th0;
   logic [TW-1:0] blend_th1;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    w_s;
   logic [7:0]    w_f;
   logic          busy;

   blend_weight_seq #(
      .pixelBitWidth    (PW),
      .thresholdBitWidth(TW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .diff     (diff),
      .blend_th0(blend_th0),
      .blend_th1(blend_th1),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .w_s      (w_s),
      .w_f      (w_f),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // cyc equals n after the n-th rising edge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] ws;
      logic [7:0] wf;
      int         rise;   // cyc value when out_valid is first seen
      int         stall;  // cycles to hold out_ready low
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // -------------------------------------------------------------------------
   // Monitor / scoreboard
   // -------------------------------------------------------------------------
   initial begin : monitor
      exp_t e;
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst && out_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("w_s", {24'd0, w_s}, {24'd0, e.ws});
               check("w_f", {24'd0, w_f}, {24'd0, e.wf});
               check("latency", cyc, e.rise);
               check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
               for (int i = 0; i < e.stall; i++) begin
                  @(negedge clk);
                  check("hold_out_valid", {31'd0, out_valid}, 32'd1);
                  check("hold_w_s", {24'd0, w_s}, {24'd0, e.ws});
                  check("hold_w_f", {24'd0, w_f}, {24'd0, e.wf});
                  check("hold_in_ready", {31'd0, in_ready}, 32'd0);
               end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("out_valid_cleared", {31'd0, out_valid}, 32'd0);
            check("in_ready_after_done", {31'd0, in_ready}, 32'd1);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------
   task automatic send(input logic [PW:0] d, input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                       input logic [7:0] ws, input logic [7:0] wf,
                       input int lat, input int stall, input bit push);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 32'd0, 32'd1);
         return;
      end
      in_valid  = 1'b1;
      diff      = d;
      blend_th0 = t0;
      blend_th1 = t1;
      @(posedge clk);
      #1;
      if (push) begin
         e.ws    = ws;
         e.wf    = wf;
         e.rise  = cyc + lat - 1;
         e.stall = stall;
         sb.push_back(e);
      end
      // Inputs after the accept must not affect the result.
      in_valid  = 1'b0;
      diff      = '1;
      blend_th0 = '0;
      blend_th1 = '1;
   endtask

   initial begin : stimulus
      int n;
      in_valid  = 1'b0;
      diff      = '0;
      blend_th0 = '0;
      blend_th1 = '0;
      rst       = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_w_s", {24'd0, w_s}, 32'd0);
      check("rst_w_f", {24'd0, w_f}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      //     diff  th0  th1  w_s    w_f    lat stall
      send(13'd50,  9'd100, 9'd300, 8'hFF, 8'h00,  2, 0, 1);  // below th0
      send(13'd350, 9'd100, 9'd300, 8'h00, 8'hFF,  2, 0, 1);  // above th1
      send(13'd200, 9'd100, 9'd300, 8'h7F, 8'h7F, 18, 0, 1);  // midpoint
      send(13'd100, 9'd100, 9'd300, 8'hFF, 8'h00, 18, 0, 1);  // diff == th0, df = 0
      send(13'd300, 9'd100, 9'd300, 8'h00, 8'hFF, 18, 0, 1);  // diff == th1, ds = 0
      send(13'd200, 9'd300, 9'd100, 8'h00, 8'h00,  2, 0, 1);  // inverted thresholds
      send(13'd150, 9'd150, 9'd150, 8'hFF, 8'h00,  2, 0, 1);  // zero span
      send(13'd1,   9'd0,   9'd3,   8'hAA, 8'h55, 18, 0, 1);  // 511/3, 255/3
      send(13'd1,   9'd0,   9'd511, 8'hFF, 8'h00, 18, 0, 1);  // 130559/511, 255/511
      send(13'd250, 9'd100, 9'd300, 8'h3F, 8'hBF, 18, 5, 1);  // backpressure
      send(13'd8191, 9'd0,  9'd511, 8'h00, 8'hFF,  2, 3, 1);  // wide diff above th1

      // Reset abort in the middle of DIV_F.
      send(13'd200, 9'd100, 9'd300, 8'h00, 8'h00, 18, 0, 0);
      repeat (4) @(negedge clk);
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      #1;
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_w_s", {24'd0, w_s}, 32'd0);
      check("abort_w_f", {24'd0, w_f}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (20) @(negedge clk);
      check("abort_no_output", {31'd0, out_valid}, 32'd0);

      send(13'd200, 9'd100, 9'd300, 8'h7F, 8'h7F, 18, 0, 1);  // after abort

      n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue", sb.size(), 32'd0);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #200000;
      fails++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/blend_weight_seq.md
# blend_weight_seq

Sequenced, area-reduced computation of the static/fast blend weights w_s and w_f from an absolute pixel difference and two blend thresholds. A single shared 8-iteration restoring divider serves both weights in turn, replacing two parallel combinational dividers. The block sits between the difference stage and the blend mixer and uses a valid/ready handshake on both sides.

## Interface

Parameters:
- pixelBitWidth, 12: pixel width; diff is pixelBitWidth+1 bits.
- thresholdBitWidth, 9: width of blend thresholds and of the divisor.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: request carries valid diff/thresholds.
- in_ready, output, 1: block can accept a request.
- diff, input, pixelBitWidth+1: absolute difference.
- blend_th0, input, thresholdBitWidth: lower threshold.
- blend_th1, input, thresholdBitWidth: upper threshold.
- out_valid, output, 1: w_s/w_f hold a new result.
- out_ready, input, 1: consumer takes the result.
- w_s, output, 8: static weight, registered.
- w_f, output, 8: fast weight, registered.
- busy, output, 1: high in any state other than IDLE.

## Operation

- FSM states: IDLE, CHECK, DIV_F, DIV_S, DONE.
- IDLE: in_ready=1. An accept (in_valid&in_ready) registers diff, th0 and th1, then moves to CHECK. Input changes after the accept are ignored.
- CHECK: evaluate lt = diff<th0 and gt = diff>th1. Comparisons are unsigned; thresholds are zero-extended.
  - lt&gt (inverted thresholds): w_s=00, w_f=00 -> DONE.
  - lt only: w_s=FF, w_f=00 -> DONE.
  - gt only: w_s=00, w_f=FF -> DONE.
  - neither, with D = th1-th0 = 0: w_s=FF, w_f=00 -> DONE.
  - neither, with D>0: latch D (9 bits), df = (diff-th0)[8:0] and ds = (th1-diff)[8:0] -> DIV_F.
- Division of operand d by D:
  - d=0: quotient forced to 00. The divider still runs its 8 cycles.
  - d>0: dividend N = d*256-1 (17 bits). Because d≤D, N < D*256 and the quotient fits in 8 bits with no saturation.
  - Restoring algorithm: initial partial remainder = N[16:8], which is less than D. Over 8 iterations, MSB first, each iteration shifts in the next bit of N[7:0]. If the shifted remainder (10 bits) ≥ D, subtract D and set the quotient bit.
  - Result is floor((d*256-1)/D).
- DIV_F: 8 cycles on df; the quotient is written to w_f. DIV_S then runs 8 cycles on ds; the quotient is written to w_s.
- DONE: out_valid=1. w_s and w_f are stable until out_ready=1, then the FSM returns to IDLE. There is no accept in DONE.
- w_s and w_f keep the last result in all states; they change only on the transitions into DONE/DIV_S completion.

## Timing

- Reset (rst low, async): state=IDLE, out_valid=0, w_s=00, w_f=00, busy=0, iteration counter=0. in_ready=1 once rst is released.
- Accept at edge E0: CHECK in cycle E0+1.
- Fast path (saturated, inverted or D=0): out_valid high from E0+2.
- Divide path: DIV_F in cycles E0+2..E0+9, DIV_S in E0+10..E0+17, out_valid high from E0+18.
- Handshake completion: out_valid&out_ready at edge Ek puts the FSM in IDLE at Ek+1. The next accept is possible at edge Ek+1.
- Minimum request spacing: 3 cycles on the fast path, 19 on the divide path.
- Reset mid-operation aborts the calculation. No out_valid is produced for the aborted request; outputs go to their reset values.
- out_valid never deasserts without out_ready.

## Test plan

- th0=100, th1=300, diff=50 -> w_s=FF, w_f=00, out_valid at accept+2.
- th0=100, th1=300, diff=350 -> w_s=00, w_f=FF at accept+2.
- th0=100, th1=300, diff=200 -> w_f=7F, w_s=7F at accept+18.
- th0=100, th1=300, diff=100 -> w_f=00, w_s=FF via the divide path at accept+18.
- th0=300, th1=100, diff=200 -> 00/00. Separately, th0=th1=150, diff=150 -> FF/00 at accept+2.
- Backpressure and reset abort:
  - out_ready held low for 5 cycles: out_valid, w_s and w_f stay stable and in_ready stays 0.
  - rst pulsed low in DIV_F: block returns to IDLE and all outputs are 0.
  - A following request completes correctly.
